rl_1r1u_arb: RTL

RL_1R1U_ARB -- requirements
Module: rl_1r1u_arb

---
 rtl/rl_1r1u_arb_if.sv | 37 +++
 rtl/rl_1r1u_arb.sv | 130 +++++++++++++
 2 files changed

// File: rtl/rl_1r1u_arb_if.sv
// Requester, memory and response signals shared between the 1r1u arbiter and its environment.
interface rl_1r1u_arb_if #(
    parameter int NUMREQ  = 4,
    parameter int BITREQ  = 2,
    parameter int WIDTH   = 32,
    parameter int BITADDR = 13
);
    logic [NUMREQ-1:0]         req_read;
    logic [NUMREQ*BITADDR-1:0] req_adr;
    logic [NUMREQ-1:0]         rd_gnt;
    logic [NUMREQ-1:0]         req_write;
    logic [NUMREQ*WIDTH-1:0]   req_din;
    logic [NUMREQ-1:0]         wr_gnt;
    logic                      mem_ready;
    logic                      mem_read;
    logic [BITADDR-1:0]        mem_rd_adr;
    logic                      mem_write;
    logic [WIDTH-1:0]          mem_din;
    logic                      mem_rd_vld;
    logic [WIDTH-1:0]          mem_rd_dout;
    logic [NUMREQ-1:0]         rsp_vld;
    logic [WIDTH-1:0]          rsp_dout;
    logic [3:0]                outstd;
    logic                      seq_err;

    modport slave (
        input  req_read, req_adr, req_write, req_din, mem_ready, mem_rd_vld, mem_rd_dout,
        output rd_gnt, wr_gnt, mem_read, mem_rd_adr, mem_write, mem_din,
               rsp_vld, rsp_dout, outstd, seq_err
    );

    modport master (
        output req_read, req_adr, req_write, req_din, mem_ready, mem_rd_vld, mem_rd_dout,
        input  rd_gnt, wr_gnt, mem_read, mem_rd_adr, mem_write, mem_din,
               rsp_vld, rsp_dout, outstd, seq_err
    );
endinterface

// File: rtl/rl_1r1u_arb.sv
// Round-robin sharing of one read port and one update port of a 1r1u memory among NUMREQ
// requesters; read returns are steered back by a fixed-latency tag pipeline.
module rl_1r1u_arb #(
    parameter int NUMREQ  = 4,
    parameter int BITREQ  = 2,
    parameter int WIDTH   = 32,
    parameter int BITADDR = 13,
    parameter int RD_LAT  = 3
) (
    input logic          clk,
    input logic          rst,
    rl_1r1u_arb_if.slave bus
);
    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e              state_q, state_d;
    logic [BITREQ-1:0]   rr_rd_q, rr_rd_d, rr_wr_q, rr_wr_d;
    logic [RD_LAT-1:0]   tag_vld_q;
    logic [BITREQ-1:0]   tag_idx_q [RD_LAT];
    logic [3:0]          outstd_q, outstd_d;
    logic                seq_err_q, seq_err_d;
    logic                grant_en, rd_hit, wr_hit, tail_vld;
    logic [BITREQ:0]     rd_pick, wr_pick;
    logic [BITREQ-1:0]   rd_idx, wr_idx, tail_idx;

    // First asserted request at or above ptr, wrapping; MSB of the result flags a hit.
    function automatic logic [BITREQ:0] rr_pick(input logic [NUMREQ-1:0] req,
                                                input logic [BITREQ-1:0] ptr);
        logic              hit;
        logic [BITREQ-1:0] idx;
        int                c;
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < NUMREQ; i++) begin
            c = int'(ptr) + i;
            if (c >= NUMREQ) c = c - NUMREQ;
            if (!hit && req[BITREQ'(c)]) begin
                hit = 1'b1;
                idx = BITREQ'(c);
            end
        end
        return {hit, idx};
    endfunction

    function automatic logic [BITREQ-1:0] rr_next(input logic [BITREQ-1:0] k);
        return (int'(k) == NUMREQ - 1) ? '0 : k + 1'b1;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (bus.mem_ready)  state_d = ST_RUN;
            ST_RUN:  if (!bus.mem_ready) state_d = ST_INIT;
            default: state_d = ST_INIT;
        endcase

        // A falling mem_ready blocks grants in the very cycle it drops.
        grant_en = (state_q == ST_RUN) && bus.mem_ready;
        rd_pick  = rr_pick(bus.req_read, rr_rd_q);
        wr_pick  = rr_pick(bus.req_write, rr_wr_q);
        rd_hit   = rd_pick[BITREQ] & grant_en;
        wr_hit   = wr_pick[BITREQ] & grant_en;
        rd_idx   = rd_pick[BITREQ-1:0];
        wr_idx   = wr_pick[BITREQ-1:0];

        bus.rd_gnt     = '0;
        bus.mem_read   = 1'b0;
        bus.mem_rd_adr = '0;
        rr_rd_d        = rr_rd_q;
        if (rd_hit) begin
            bus.rd_gnt[rd_idx] = 1'b1;
            bus.mem_read       = 1'b1;
            bus.mem_rd_adr     = bus.req_adr[rd_idx*BITADDR +: BITADDR];
            rr_rd_d            = rr_next(rd_idx);
        end

        bus.wr_gnt    = '0;
        bus.mem_write = 1'b0;
        bus.mem_din   = '0;
        rr_wr_d       = rr_wr_q;
        if (wr_hit) begin
            bus.wr_gnt[wr_idx] = 1'b1;
            bus.mem_write      = 1'b1;
            bus.mem_din        = bus.req_din[wr_idx*WIDTH +: WIDTH];
            rr_wr_d            = rr_next(wr_idx);
        end

        tail_vld    = tag_vld_q[RD_LAT-1];
        tail_idx    = tag_idx_q[RD_LAT-1];
        bus.rsp_vld = '0;
        if (tail_vld && bus.mem_rd_vld) bus.rsp_vld[tail_idx] = 1'b1;
        bus.rsp_dout = bus.mem_rd_vld ? bus.mem_rd_dout : '0;

        outstd_d = outstd_q;
        case ({rd_hit, tail_vld})
            2'b10:   outstd_d = outstd_q + 4'd1;
            2'b01:   outstd_d = outstd_q - 4'd1;
            default: outstd_d = outstd_q;
        endcase
        seq_err_d = seq_err_q | (tail_vld != bus.mem_rd_vld);

        bus.outstd  = outstd_q;
        bus.seq_err = seq_err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_INIT;
            rr_rd_q   <= '0;
            rr_wr_q   <= '0;
            tag_vld_q <= '0;
            outstd_q  <= '0;
            seq_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_rd_q      <= rr_rd_d;
            rr_wr_q      <= rr_wr_d;
            tag_vld_q[0] <= rd_hit;
            for (int i = 1; i < RD_LAT; i++) tag_vld_q[i] <= tag_vld_q[i-1];
            outstd_q     <= outstd_d;
            seq_err_q    <= seq_err_d;
        end
    end

    // Requester index travels without reset; it is only consumed when its valid bit is set.
    always_ff @(posedge clk) begin
        tag_idx_q[0] <= rd_idx;
        for (int i = 1; i < RD_LAT; i++) tag_idx_q[i] <= tag_idx_q[i-1];
    end
endmodule
